// File: rtl/error_frame_generator.sv
// ============================================================================
// error_frame_generator
// ----------------------------------------------------------------------------
// Builds FL-bit error frames that contain exactly a requested number of set
// bits at pseudo-random positions. Positions come from a 16-bit Fibonacci
// LFSR (x^16+x^14+x^13+x^11+1). One candidate position is tried per cycle.
// A candidate that is out of range or already set is dropped. The finished
// frame is offered on a valid/ready handshake.
//
// Ports
//   Clock         in   1       system clock, rising edge
//   Reset         in   1       asynchronous, active-high reset
//   Seed_Load     in   1       in IDLE: load Seed into the LFSR (0 -> 1)
//   Seed          in   LFSR_W  LFSR seed
//   Start         in   1       in IDLE: begin a new frame
//   Error_Weight  in   7       requested set bits, clamped to FL
//   Frame_Ready   in   1       consumer accepts the frame
//   Frame_Valid   out  1       b1_error holds a complete frame
//   b1_error      out  FL      error frame, bit i set = error at position i
//   Placed_Count  out  7       number of set bits in b1_error
//   Busy          out  1       generator is not idle
//
// Parameters
//   FL      frame length in bits, 2..127
//   LFSR_W  LFSR width; the taps are fixed, so only 16 is meaningful
// ============================================================================
module error_frame_generator #(
    parameter int FL     = 104,
    parameter int LFSR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Seed_Load,
    input  logic [LFSR_W-1:0] Seed,
    input  logic              Start,
    input  logic [6:0]        Error_Weight,
    input  logic              Frame_Ready,
    output logic              Frame_Valid,
    output logic [FL-1:0]     b1_error,
    output logic [6:0]        Placed_Count,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [6:0]        FL_W     = 7'(FL);
    localparam logic [LFSR_W-1:0] LFSR_ONE = LFSR_W'(1);

    state_t              state, next_state;
    logic [LFSR_W-1:0]   lfsr, lfsr_n;
    logic [FL-1:0]       frame_n;
    logic [6:0]          placed_n;
    logic [6:0]          remaining, remaining_n;
    logic [6:0]          pos;
    logic                fb;

    // Only the low 7 LFSR bits pick the position. The full 16-bit period
    // visits every 7-bit value, so even weight FL always terminates.
    assign pos = lfsr[6:0];
    assign fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Next-state and datapath decode
    always_comb begin
        // NOTE: every variable gets a default before the case statement.
        // A path that does not assign a variable would otherwise infer a latch.
        next_state  = state;
        lfsr_n      = lfsr;
        frame_n     = b1_error;
        placed_n    = Placed_Count;
        remaining_n = remaining;

        unique case (state)
            IDLE: begin
                // The seed is applied first, so a Start in the same cycle
                // draws its first candidate from the new seed.
                if (Seed_Load) begin
                    lfsr_n = (Seed == '0) ? LFSR_ONE : Seed;
                end
                if (Start) begin
                    frame_n     = '0;
                    placed_n    = '0;
                    remaining_n = (Error_Weight > FL_W) ? FL_W : Error_Weight;
                    next_state  = PLACE;
                end
            end

            PLACE: begin
                if (remaining == '0) begin
                    // Completion cycle: the LFSR holds its value so that the
                    // next frame continues the same sequence.
                    next_state = HOLD;
                end else begin
                    lfsr_n = {lfsr[LFSR_W-2:0], fb};
                    if ((pos < FL_W) && !b1_error[pos]) begin
                        frame_n[pos] = 1'b1;
                        remaining_n  = remaining - 7'd1;
                        placed_n     = Placed_Count + 7'd1;
                    end
                end
            end

            HOLD: begin
                // Frame_Valid is high for exactly the cycles spent in HOLD,
                // so the handshake reduces to Frame_Ready.
                if (Frame_Ready) begin
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_ONE;
            b1_error     <= '0;
            Placed_Count <= '0;
            remaining    <= '0;
            Frame_Valid  <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so all
            // registers update together from the values present before the edge.
            state        <= next_state;
            lfsr         <= lfsr_n;
            b1_error     <= frame_n;
            Placed_Count <= placed_n;
            remaining    <= remaining_n;
            // Flags are decoded from next_state so they line up with state.
            Frame_Valid  <= (next_state == HOLD);
            Busy         <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_error_frame_generator.sv
// ============================================================================
// tb_error_frame_generator
// ----------------------------------------------------------------------------
// Randomised bench for error_frame_generator. A behavioural model draws LFSR
// values and collects distinct in-range positions in a set until the clamped
// weight is reached. The model predicts the frame contents, the number of
// cycles to Frame_Valid, and the LFSR value carried into the next frame.
// ============================================================================
module tb_error_frame_generator;

    localparam int FL = 104;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Seed_Load;
    logic [15:0]   Seed;
    logic          Start;
    logic [6:0]    Error_Weight;
    logic          Frame_Ready;
    logic          Frame_Valid;
    logic [FL-1:0] b1_error;
    logic [6:0]    Placed_Count;
    logic          Busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] model_lfsr;

    error_frame_generator #(.FL(FL), .LFSR_W(16)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Seed_Load    (Seed_Load),
        .Seed         (Seed),
        .Start        (Start),
        .Error_Weight (Error_Weight),
        .Frame_Ready  (Frame_Ready),
        .Frame_Valid  (Frame_Valid),
        .b1_error     (b1_error),
        .Placed_Count (Placed_Count),
        .Busy         (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One LFSR step, written with plain arithmetic on an int
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int v, b;
        v = int'(s);
        b = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | b) & 16'hFFFF);
    endfunction

    // Draws positions until the set holds the clamped weight.
    // cand counts every draw, including rejected ones.
    task automatic model_place(input int w, input logic [15:0] s0,
                               output logic [FL-1:0] f, output int cand,
                               output logic [15:0] s_end);
        bit seen[int];
        int target, p;
        logic [15:0] s;
        target = (w > FL) ? FL : w;
        s = s0;
        cand = 0;
        f = '0;
        while (seen.num() < target) begin
            p = int'(s) % 128;
            cand++;
            if (p < FL && !seen.exists(p)) seen[p] = 1'b1;
            s = lfsr_step(s);
        end
        foreach (seen[k]) f[k] = 1'b1;
        s_end = s;
    endtask

    task automatic do_reset();
        Start = 0; Seed_Load = 0; Frame_Ready = 0; Seed = '0; Error_Weight = '0;
        Reset = 1;
        @(posedge Clock); #1;
        Reset = 0;
        model_lfsr = 16'h0001;
    endtask

    task automatic load_seed(input logic [15:0] sd);
        Seed_Load = 1; Seed = sd;
        @(posedge Clock); #1;
        Seed_Load = 0;
        model_lfsr = (sd == 16'h0) ? 16'h0001 : sd;
    endtask

    // Runs one frame from IDLE. When disturb is set, Start, Seed_Load, Seed
    // and Frame_Ready are randomised while the generator is busy.
    task automatic run_frame(input int w, input bit ld, input logic [15:0] sd,
                             input int hold, input bit disturb);
        logic [FL-1:0] exp_f;
        logic [15:0]   s_end;
        int cand, n, wc;
        wc = (w > FL) ? FL : w;
        if (ld) model_lfsr = (sd == 16'h0) ? 16'h0001 : sd;
        model_place(w, model_lfsr, exp_f, cand, s_end);

        Error_Weight = 7'(w); Start = 1; Seed_Load = ld; Seed = sd;
        @(posedge Clock); #1;
        Start = 0; Seed_Load = 0;
        check("busy_after_start", Busy, 1);

        n = 0;
        while (!Frame_Valid && n < 5000) begin
            if (disturb) begin
                Start = 1'($urandom); Seed_Load = 1'($urandom);
                Seed = 16'($urandom); Frame_Ready = 1'($urandom);
                Error_Weight = 7'($urandom);
            end
            @(posedge Clock); #1;
            n++;
        end
        Frame_Ready = 0;
        check("latency", n, cand + 1);
        if (n >= 5000) begin
            do_reset();
            return;
        end
        check("frame", b1_error, exp_f);
        check("placed_count", Placed_Count, wc);
        check("popcount", $countones(b1_error), wc);

        for (int i = 0; i < hold; i++) begin
            if (disturb) begin
                Start = 1'($urandom); Seed_Load = 1'($urandom); Seed = 16'($urandom);
            end
            @(posedge Clock); #1;
            check("hold_valid", Frame_Valid, 1);
            check("hold_frame", b1_error, exp_f);
            check("hold_count", Placed_Count, wc);
        end

        Start = 0; Seed_Load = 0; Frame_Ready = 1;
        @(posedge Clock); #1;
        Frame_Ready = 0;
        check("valid_drop", Frame_Valid, 0);
        check("busy_drop", Busy, 0);
        check("frame_kept", b1_error, exp_f);
        model_lfsr = s_end;
    endtask

    initial begin
        Start = 0; Seed_Load = 0; Frame_Ready = 0; Seed = '0; Error_Weight = '0;
        Reset = 1;
        repeat (2) @(posedge Clock);
        #1 Reset = 0;
        model_lfsr = 16'h0001;
        check("rst_valid", Frame_Valid, 0);
        check("rst_frame", b1_error, 0);
        check("rst_count", Placed_Count, 0);
        check("rst_busy", Busy, 0);

        // Reset in the middle of PLACE; the following frame starts from LFSR=1
        Error_Weight = 7'd50; Start = 1;
        @(posedge Clock); #1;
        Start = 0;
        repeat (10) @(posedge Clock);
        #1;
        do_reset();
        check("midrst_valid", Frame_Valid, 0);
        check("midrst_frame", b1_error, 0);
        check("midrst_count", Placed_Count, 0);
        check("midrst_busy", Busy, 0);
        run_frame(5, 0, 16'h0, 0, 0);

        // Weight 0
        run_frame(0, 0, 16'h0, 1, 0);

        // Seed ACE1, weight 10, Ready held low for 20 cycles
        run_frame(10, 1, 16'hACE1, 20, 0);

        // Weight above FL clamps to every bit set
        run_frame(127, 0, 16'h0, 1, 0);
        check("all_ones", b1_error, {FL{1'b1}});

        // Inputs toggled while busy; zero seed in IDLE loads 1
        run_frame(30, 1, 16'h1234, 3, 1);
        load_seed(16'h0000);
        run_frame(8, 0, 16'h0, 0, 0);
        run_frame(20, 1, 16'h0000, 0, 1);

        // Random frames
        for (int k = 0; k < 30; k++) begin
            logic [15:0] sd;
            sd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 4) == 0) load_seed(16'($urandom));
            run_frame($urandom_range(0, 127), 1'($urandom), sd, $urandom_range(0, 3), 1);
        end

        // Weight sweep; popcount at each handshake must equal Placed_Count
        for (int w = 1; w <= FL; w++) run_frame(w, 0, 16'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
